// File: rtl/sisc_fetch.sv
// -----------------------------------------------------------------------------
// sisc_fetch
//   Instruction fetch stage of the SISC datapath. Holds the program counter,
//   requests one instruction word from instruction memory, latches it into the
//   32-bit instruction register (ir), and advances the PC when ctrl retires the
//   instruction. The PC advances to either PC+1 or a branch target.
//
// Configuration macro:
//   PC_RELATIVE_BR_EN  defined   : branch target = pc + 1 + sign-extend(br_imm)
//                      undefined : branch target = zero-extend(br_imm) (absolute)
//   The handshake and all cycle timing are the same in both builds.
//
// Ports:
//   clk         in   1     system clock, rising edge
//   rst_f       in   1     asynchronous active-low reset
//   pc_write    in   1     one-cycle retire pulse from ctrl (acts only in HOLD)
//   br_taken    in   1     with pc_write: 1 = load branch target, 0 = pc+1
//   br_imm      in   16    branch operand (normally ir[15:0])
//   stall       in   1     freezes PC update and instruction capture
//   imem_req    out  1     fetch request to instruction memory
//   imem_addr   out  PC_W  fetch address (always equals pc)
//   imem_rdata  in   IR_W  memory read data
//   imem_valid  in   1     memory read data valid
//   ir          out  IR_W  instruction register
//   ir_valid    out  1     ir holds a fetched, not-yet-retired instruction
//   pc          out  PC_W  program counter
//   fsm_state   out  2     debug view of the fetch FSM (IDLE/REQ/HOLD)
//
// Handshake: imem_req is the "ready" side and imem_valid the "valid" side of a
// single transfer. A word is accepted on a rising edge where imem_req=1,
// imem_valid=1 and stall=0; imem_addr is held stable from the first request
// cycle until that edge. imem_valid with imem_req=0, or during stall, is not a
// transfer and the memory must present the word again later.
// -----------------------------------------------------------------------------
module sisc_fetch #(
  parameter int              PC_W     = 16,
  parameter int              IR_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            pc_write,
  input  logic            br_taken,
  input  logic [15:0]     br_imm,
  input  logic            stall,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IR_W-1:0] imem_rdata,
  input  logic            imem_valid,
  output logic [IR_W-1:0] ir,
  output logic            ir_valid,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]      state;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] next_pc;

`ifdef PC_RELATIVE_BR_EN
  // Sign-extending cast of the signed operand; the sum wraps modulo 2^PC_W.
  assign br_target = pc + PC_W'(1) + PC_W'($signed(br_imm));
`else
  assign br_target = PC_W'(br_imm);
`endif

  assign next_pc = br_taken ? br_target : (pc + PC_W'(1));

  // Request and address are decoded straight from registered state, so they
  // drop asynchronously with reset and never glitch on input changes.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          // imem_rdata is only looked at on an accepted transfer, so X on the
          // bus while valid is low never reaches ir.
          if (imem_valid && !stall) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          // A retire pulse that collides with stall is dropped, not queued.
          if (pc_write && !stall) begin
            pc       <= next_pc;
            ir_valid <= 1'b0;
            state    <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_fetch.sv
// -----------------------------------------------------------------------------
// tb_sisc_fetch
//   Directed bench for sisc_fetch. Driver tasks issue fetch/retire stimulus and
//   push the expected fetch address / instruction word into queues; a negedge
//   monitor pops and compares whenever the DUT raises imem_req or ir_valid.
//   Cycle-level boundary behaviour is checked directly in the driver tasks.
// -----------------------------------------------------------------------------
module tb_sisc_fetch;
  localparam int PC_W = 16;
  localparam int IR_W = 32;

  logic            clk = 1'b0;
  logic            rst_f = 1'b1;
  logic            pc_write = 1'b0;
  logic            br_taken = 1'b0;
  logic [15:0]     br_imm = '0;
  logic            stall = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [IR_W-1:0] imem_rdata = 'x;
  logic            imem_valid = 1'b0;
  logic [IR_W-1:0] ir;
  logic            ir_valid;
  logic [PC_W-1:0] pc;
  logic [1:0]      fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [PC_W-1:0] exp_addr_q[$];
  logic [IR_W-1:0] exp_q[$];
  logic [PC_W-1:0] cur_addr = '0;
  logic            prev_req = 1'b0;
  logic            prev_irv = 1'b0;

  sisc_fetch #(.PC_W(PC_W), .IR_W(IR_W), .RESET_PC('0)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .pc_write   (pc_write),
    .br_taken   (br_taken),
    .br_imm     (br_imm),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .pc         (pc),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Operand that makes a taken branch land on tgt from cur.
  function automatic logic [15:0] imm_for(input logic [15:0] cur, input logic [15:0] tgt);
`ifdef PC_RELATIVE_BR_EN
    return tgt - cur - 16'd1;
`else
    return tgt;
`endif
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_f) begin
      prev_req = 1'b0;
      prev_irv = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected_request", 32'(imem_addr), 32'hFFFF_FFFF);
        end else begin
          cur_addr = exp_addr_q.pop_front();
          check("req_addr", 32'(imem_addr), 32'(cur_addr));
        end
      end else if (imem_req) begin
        check("req_addr_stable", 32'(imem_addr), 32'(cur_addr));
      end
      if (ir_valid && !prev_irv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", ir, 32'hFFFF_FFFF);
        end else begin
          check("ir_word", ir, exp_q.pop_front());
        end
      end
      prev_req = imem_req;
      prev_irv = ir_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // Called during a REQ cycle (2 units after the edge); returns in HOLD.
  task automatic fetch(input logic [IR_W-1:0] data, input int waits);
    logic [IR_W-1:0] old_ir;
    old_ir = ir;
    exp_q.push_back(data);
    for (int i = 0; i < waits; i++) begin
      imem_valid = 1'b0;
      @(posedge clk); #1;
      check("wait_req_held", 32'(imem_req), 32'd1);
      check("wait_ir_unchanged", ir, old_ir);
      #1;
    end
    imem_valid = 1'b1;
    imem_rdata = data;
    @(posedge clk); #1;
    check("fetch_ir_valid", 32'(ir_valid), 32'd1);
    check("fetch_req_drop", 32'(imem_req), 32'd0);
    #1;
    imem_valid = 1'b0;
    imem_rdata = 'x;
  endtask

  // Called during HOLD; returns in the following REQ cycle.
  task automatic retire(input logic br, input logic [15:0] imm, input logic [PC_W-1:0] exp_pc);
    pc_write = 1'b1;
    br_taken = br;
    br_imm   = imm;
    exp_addr_q.push_back(exp_pc);
    @(posedge clk); #1;
    check("retire_pc", 32'(pc), 32'(exp_pc));
    check("retire_addr", 32'(imem_addr), 32'(exp_pc));
    check("retire_ir_valid", 32'(ir_valid), 32'd0);
    check("retire_req", 32'(imem_req), 32'd1);
    #1;
    pc_write = 1'b0;
    br_taken = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] p;

    // Reset asserted mid-cycle: outputs must settle with no clock edge.
    #8 rst_f = 1'b0;
    #1;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    exp_addr_q.push_back(16'h0000);
    @(posedge clk); @(posedge clk); #2;
    rst_f = 1'b1;
    @(posedge clk); #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", 32'(imem_addr), 32'd0);
    #1;

    // Zero-wait fetch.
    fetch(32'h88123000, 0);
    check("zw_ir", ir, 32'h88123000);

    // Branch to 5, then a 3-wait-state fetch.
    retire(1'b1, imm_for(16'h0000, 16'h0005), 16'h0005);
    fetch(32'h11110001, 3);

    // stall wins over pc_write in HOLD.
    stall = 1'b1; pc_write = 1'b1;
    @(posedge clk); #1;
    check("stall_pcw_pc", 32'(pc), 32'd5);
    check("stall_pcw_irv", 32'(ir_valid), 32'd1);
    check("stall_pcw_req", 32'(imem_req), 32'd0);
    #1 stall = 1'b0; pc_write = 1'b0;

    // br_taken alone does nothing.
    br_taken = 1'b1; br_imm = 16'h1234;
    @(posedge clk); #1;
    check("br_only_pc", 32'(pc), 32'd5);
    check("br_only_irv", 32'(ir_valid), 32'd1);
    #1 br_taken = 1'b0;

    // imem_valid without a request is ignored.
    imem_valid = 1'b1; imem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("valid_no_req_ir", ir, 32'h11110001);
    #1 imem_valid = 1'b0; imem_rdata = 'x;

    // Sequential advance 5 -> 6.
    retire(1'b0, 16'h0000, 16'h0006);

    // pc_write in REQ is ignored.
    pc_write = 1'b1;
    @(posedge clk); #1;
    check("pcw_in_req_pc", 32'(pc), 32'd6);
    check("pcw_in_req_req", 32'(imem_req), 32'd1);
    #1 pc_write = 1'b0;

    // Data arriving under stall is ignored; memory re-presents later.
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    check("stall_req_ir", ir, 32'h11110001);
    check("stall_req_irv", 32'(ir_valid), 32'd0);
    check("stall_req_req", 32'(imem_req), 32'd1);
    #1 stall = 1'b0; imem_valid = 1'b0; imem_rdata = 'x;
    fetch(32'h22220002, 1);

    // Back to 5, then branch with operand 0x0040.
    retire(1'b1, imm_for(16'h0006, 16'h0005), 16'h0005);
    fetch(32'h33330003, 0);
`ifdef PC_RELATIVE_BR_EN
    retire(1'b1, 16'h0040, 16'h0046);
`else
    retire(1'b1, 16'h0040, 16'h0040);
`endif
    fetch(32'h44440004, 2);

    // Back to 5, then branch with operand 0xFFFE.
    p = pc;
    retire(1'b1, imm_for(p, 16'h0005), 16'h0005);
    fetch(32'h55550005, 0);
`ifdef PC_RELATIVE_BR_EN
    retire(1'b1, 16'hFFFE, 16'h0004);
`else
    retire(1'b1, 16'hFFFE, 16'hFFFE);
`endif
    fetch(32'h66660006, 0);

    // Wrap 0xFFFF + 1 -> 0.
    p = pc;
    retire(1'b1, imm_for(p, 16'hFFFF), 16'hFFFF);
    fetch(32'h77770007, 1);
    retire(1'b0, 16'h0000, 16'h0000);
    fetch(32'h88880008, 0);

    // Reset during REQ with valid pending, valid still high after release.
    retire(1'b0, 16'h0000, 16'h0001);
    imem_valid = 1'b1; imem_rdata = 32'h99990009;
    #1 rst_f = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_ir", ir, 32'd0);
    check("mid_rst_irv", 32'(ir_valid), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    exp_addr_q.delete();
    exp_q.delete();
    exp_addr_q.push_back(16'h0000);
    @(posedge clk); @(posedge clk); #2;
    rst_f = 1'b1;
    @(posedge clk); #1;
    check("late_valid_ir", ir, 32'd0);
    check("late_valid_irv", 32'(ir_valid), 32'd0);
    check("late_valid_req", 32'(imem_req), 32'd1);
    #1 imem_valid = 1'b0; imem_rdata = 'x;
    fetch(32'hAAAA000A, 0);

    @(posedge clk); #1;
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("ir_q_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
